atm_session_ctrl: RTL
=====================

Name: atm_session_ctrl

Overview:
- Parametrised, session-based ATM controller.
- Holds a per-account database of balance, PIN, retry count and lock flag.
- Authenticates a login, then serves balance, withdraw, deposit, change-PIN and logout requests over valid/ready handshakes.
- Adds PIN-retry lockout, session inactivity timeout, per-session withdrawal limit and deposit overflow protection. It sits between the front-panel/keypad logic and the host.

Parameters:
- NUM_ACC, 10, number of accounts; ACC_W = max(1, clog2(NUM_ACC)).
- BAL_W, 32, balance/amount width.
- PIN_W, 16, PIN width.
- MAX_TRIES, 3, consecutive wrong PINs that lock an account.
- TIMEOUT_CYC, 1000, idle SESSION cycles before forced logout.
- SESSION_LIMIT, 20000, maximum total withdrawn per session.
- BAL_INIT_STEP, 1000, reset balance of account i = (i+1)*BAL_INIT_STEP.
- PIN_INIT_BASE, 4660, reset PIN of account i = PIN_INIT_BASE+i.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept request
- req_op  in  3  opcode (see package)
- req_acc  in  ACC_W  account number (LOGIN only)
- req_pin  in  PIN_W  PIN (LOGIN only)
- req_new_pin  in  PIN_W  new PIN (CHANGE_PIN)
- req_amount  in  BAL_W  amount (WITHDRAW/DEPOSIT)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_status  out  4  status code
- rsp_balance  out  BAL_W  balance of session account after the operation; 0 when no session
- session_active  out  1  high in SESSION/EXEC states

Behaviour:
- Reset (async, rst low), from any state including mid-operation:
  - State goes to IDLE. All outputs go to 0, except req_ready, which goes to 1.
  - Database is reinitialised to the parameter values; tries cleared; locks cleared; session_withdrawn cleared.
- Request handshake:
  - A request is accepted on a clk edge with req_valid & req_ready. Request fields are captured at acceptance.
  - req_ready = 1 only in IDLE and SESSION.
- Response handshake:
  - rsp_valid rises 2 cycles after acceptance (accept at edge N, EXEC at N+1, RESP from N+2).
  - rsp_valid, rsp_status and rsp_balance are held stable until rsp_valid & rsp_ready.
  - On that handshake the FSM moves to its return state (IDLE or SESSION).
- States:
  - IDLE: accepts any opcode. LOGIN goes to CHECK. Any other opcode goes to RESP with ERR_BAD_OP, returning to IDLE.
  - CHECK (1 cycle):
    - req_acc >= NUM_ACC: ERR_NO_ACC.
    - Account locked: ERR_LOCKED.
    - PIN mismatch: tries+1. If tries reaches MAX_TRIES, set lock and return ERR_LOCKED, else ERR_PIN. Return to IDLE.
    - PIN match: tries cleared, session_withdrawn cleared, status OK, return to SESSION.
  - SESSION: an idle counter increments each cycle with no accepted request. It is cleared on acceptance.
    - Counter reaching TIMEOUT_CYC forces RESP with ERR_TIMEOUT (unsolicited), returning to IDLE.
    - If a request is accepted on the same edge the counter reaches TIMEOUT_CYC, the request wins.
  - EXEC (1 cycle), then RESP returning to SESSION unless noted:
    - BALANCE: OK, no change.
    - WITHDRAW:
      - amount==0 or amount>balance: ERR_FUNDS.
      - session_withdrawn+amount > SESSION_LIMIT (computed at BAL_W+1 bits): ERR_LIMIT.
      - Otherwise balance -= amount, session_withdrawn += amount, OK. amount==balance is allowed (balance becomes 0).
    - DEPOSIT: carry out of the BAL_W+1-bit sum gives ERR_OVERFLOW with no change; otherwise balance += amount, OK.
    - CHANGE_PIN: new_pin equal to the current PIN gives ERR_SAME_PIN; otherwise the PIN is written, OK.
    - LOGOUT: OK, return to IDLE, session cleared.
    - LOGIN while in session: ERR_BAD_OP, session kept.
    - Opcodes 6 and 7: ERR_BAD_OP.
- Failed operations never modify the database.
- rsp_balance is sampled after the update in EXEC. It is 0 for responses returning to IDLE, except the LOGIN OK response, which reports the balance.

Decomposition:
- Package atm_defs:
  - Opcodes: LOGIN=0, BALANCE=1, WITHDRAW=2, DEPOSIT=3, CHANGE_PIN=4, LOGOUT=5.
  - Status codes: OK=0, ERR_NO_ACC=1, ERR_PIN=2, ERR_LOCKED=3, ERR_FUNDS=4, ERR_LIMIT=5, ERR_OVERFLOW=6, ERR_SAME_PIN=7, ERR_BAD_OP=8, ERR_TIMEOUT=9.
  - FSM state encoding: IDLE, CHECK, SESSION, EXEC, RESP.
- Sub-module atm_account_store:
  - Holds the balance/PIN/tries/lock arrays with async reset initialisation.
  - One combinational read port indexed by account.
  - One synchronous write port with per-field enables.
- The FSM, timeout counter and session_withdrawn stay in atm_session_ctrl.

Test Plan:
- Login acc 2, PIN 4662 -> OK, rsp_balance 3000. BALANCE -> OK, 3000. LOGOUT -> OK, session_active 0.
- Acc 1, PINs 0, 0, 0 -> ERR_PIN, ERR_PIN, ERR_LOCKED. Then correct 4661 -> ERR_LOCKED. Async reset -> 4661 gives OK.
- Acc 9 session: WITHDRAW 10001 -> ERR_FUNDS. WITHDRAW 10000 -> OK, balance 0. Acc 4: WITHDRAW 5000, DEPOSIT 20000, WITHDRAW 15001 -> OK, OK, ERR_LIMIT.
- DEPOSIT 0xFFFFFFFF on acc 0 (1000) -> ERR_OVERFLOW, balance 1000. CHANGE_PIN 4660 -> ERR_SAME_PIN. CHANGE_PIN 7 -> OK; relogin with 7 -> OK.
- Hold rsp_ready low 5 cycles -> rsp fields stable, req_ready 0. Idle session for TIMEOUT_CYC cycles -> ERR_TIMEOUT, IDLE.
- Assert rst mid-EXEC of WITHDRAW 500 on acc 3 -> no rsp, balance 4000 after reset. BALANCE in IDLE -> ERR_BAD_OP.

Source files
------------

// File: rtl/atm_session_ctrl_pkg.sv
// Shared opcodes, status codes and FSM state encoding for the ATM session controller.
package atm_defs;

  typedef enum logic [2:0] {
    OP_LOGIN      = 3'd0,
    OP_BALANCE    = 3'd1,
    OP_WITHDRAW   = 3'd2,
    OP_DEPOSIT    = 3'd3,
    OP_CHANGE_PIN = 3'd4,
    OP_LOGOUT     = 3'd5
  } op_e;

  typedef enum logic [3:0] {
    ST_OK           = 4'd0,
    ST_ERR_NO_ACC   = 4'd1,
    ST_ERR_PIN      = 4'd2,
    ST_ERR_LOCKED   = 4'd3,
    ST_ERR_FUNDS    = 4'd4,
    ST_ERR_LIMIT    = 4'd5,
    ST_ERR_OVERFLOW = 4'd6,
    ST_ERR_SAME_PIN = 4'd7,
    ST_ERR_BAD_OP   = 4'd8,
    ST_ERR_TIMEOUT  = 4'd9
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_SESSION = 3'd2,
    S_EXEC    = 3'd3,
    S_RESP    = 3'd4
  } state_e;

endpackage

// File: rtl/atm_session_ctrl_store.sv
// Per-account balance/PIN/tries/lock storage: one combinational read port,
// one synchronous write port with per-field enables, reset to the parameter values.
module atm_account_store #(
  parameter int NUM_ACC       = 10,
  parameter int ACC_W         = 4,
  parameter int BAL_W         = 32,
  parameter int PIN_W         = 16,
  parameter int TRY_W         = 2,
  parameter int BAL_INIT_STEP = 1000,
  parameter int PIN_INIT_BASE = 4660
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] rd_acc_i,
  output logic [BAL_W-1:0] rd_bal_o,
  output logic [PIN_W-1:0] rd_pin_o,
  output logic [TRY_W-1:0] rd_tries_o,
  output logic             rd_lock_o,
  input  logic [ACC_W-1:0] wr_acc_i,
  input  logic             wr_bal_en_i,
  input  logic             wr_pin_en_i,
  input  logic             wr_tries_en_i,
  input  logic             wr_lock_en_i,
  input  logic [BAL_W-1:0] wr_bal_i,
  input  logic [PIN_W-1:0] wr_pin_i,
  input  logic [TRY_W-1:0] wr_tries_i,
  input  logic             wr_lock_i
);

  logic [BAL_W-1:0] bal_q   [NUM_ACC];
  logic [PIN_W-1:0] pin_q   [NUM_ACC];
  logic [TRY_W-1:0] tries_q [NUM_ACC];
  logic             lock_q  [NUM_ACC];

  // Out-of-range account numbers read as all-zero and never match a write.
  always_comb begin
    rd_bal_o   = '0;
    rd_pin_o   = '0;
    rd_tries_o = '0;
    rd_lock_o  = 1'b0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (rd_acc_i == ACC_W'(i)) begin
        rd_bal_o   = bal_q[i];
        rd_pin_o   = pin_q[i];
        rd_tries_o = tries_q[i];
        rd_lock_o  = lock_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        bal_q[i]   <= BAL_W'((i + 1) * BAL_INIT_STEP);
        pin_q[i]   <= PIN_W'(PIN_INIT_BASE + i);
        tries_q[i] <= '0;
        lock_q[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_ACC; i++) begin
        if (wr_acc_i == ACC_W'(i)) begin
          if (wr_bal_en_i)   bal_q[i]   <= wr_bal_i;
          if (wr_pin_en_i)   pin_q[i]   <= wr_pin_i;
          if (wr_tries_en_i) tries_q[i] <= wr_tries_i;
          if (wr_lock_en_i)  lock_q[i]  <= wr_lock_i;
        end
      end
    end
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// Session-based ATM controller: login with PIN lockout, then balance/withdraw/deposit/
// change-PIN/logout over valid/ready, with idle timeout and per-session withdrawal limit.
module atm_session_ctrl
  import atm_defs::*;
#(
  parameter int NUM_ACC       = 10,
  parameter int BAL_W         = 32,
  parameter int PIN_W         = 16,
  parameter int MAX_TRIES     = 3,
  parameter int TIMEOUT_CYC   = 1000,
  parameter int SESSION_LIMIT = 20000,
  parameter int BAL_INIT_STEP = 1000,
  parameter int PIN_INIT_BASE = 4660,
  localparam int ACC_W        = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [ACC_W-1:0] req_acc,
  input  logic [PIN_W-1:0] req_pin,
  input  logic [PIN_W-1:0] req_new_pin,
  input  logic [BAL_W-1:0] req_amount,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_status,
  output logic [BAL_W-1:0] rsp_balance,
  output logic             session_active,
  output logic [2:0]       dbg_state_o
);

  // Handshakes: a request moves on a clk edge with req_valid & req_ready; a response is
  // held unchanged from rsp_valid rising until the edge with rsp_valid & rsp_ready.
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e           state_q, state_d, ret_q, ret_d;
  status_e          status_q, status_d;
  logic [2:0]       op_q, op_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [PIN_W-1:0] pin_q, pin_d, new_pin_q, new_pin_d;
  logic [BAL_W-1:0] amt_q, amt_d, bal_q, bal_d, wdr_q, wdr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [BAL_W-1:0] rd_bal, wr_bal;
  logic [PIN_W-1:0] rd_pin, wr_pin;
  logic [TRY_W-1:0] rd_tries, wr_tries, tries_inc;
  logic             rd_lock, wr_lock;
  logic             wr_bal_en, wr_pin_en, wr_tries_en, wr_lock_en;
  logic [BAL_W:0]   wd_sum, dep_sum;

  atm_account_store #(
    .NUM_ACC(NUM_ACC), .ACC_W(ACC_W), .BAL_W(BAL_W), .PIN_W(PIN_W), .TRY_W(TRY_W),
    .BAL_INIT_STEP(BAL_INIT_STEP), .PIN_INIT_BASE(PIN_INIT_BASE)
  ) u_store (
    .clk(clk), .rst(rst),
    .rd_acc_i(acc_q), .rd_bal_o(rd_bal), .rd_pin_o(rd_pin),
    .rd_tries_o(rd_tries), .rd_lock_o(rd_lock),
    .wr_acc_i(acc_q), .wr_bal_en_i(wr_bal_en), .wr_pin_en_i(wr_pin_en),
    .wr_tries_en_i(wr_tries_en), .wr_lock_en_i(wr_lock_en),
    .wr_bal_i(wr_bal), .wr_pin_i(wr_pin), .wr_tries_i(wr_tries), .wr_lock_i(wr_lock)
  );

  assign wd_sum    = {1'b0, wdr_q} + {1'b0, amt_q};
  assign dep_sum   = {1'b0, rd_bal} + {1'b0, amt_q};
  assign tries_inc = rd_tries + TRY_W'(1);

  always_comb begin
    state_d = state_q;  ret_d = ret_q;  status_d = status_q;
    op_d = op_q;  acc_d = acc_q;  pin_d = pin_q;  new_pin_d = new_pin_q;
    amt_d = amt_q;  bal_d = bal_q;  wdr_d = wdr_q;  cnt_d = cnt_q;
    wr_bal_en = 1'b0;  wr_pin_en = 1'b0;  wr_tries_en = 1'b0;  wr_lock_en = 1'b0;
    wr_bal = '0;  wr_pin = new_pin_q;  wr_tries = '0;  wr_lock = 1'b0;
    req_ready      = (state_q == S_IDLE) || (state_q == S_SESSION);
    rsp_valid      = (state_q == S_RESP);
    session_active = (state_q == S_SESSION) || (state_q == S_EXEC);
    case (state_q)
      S_IDLE: if (req_valid) begin
        op_d = req_op;  acc_d = req_acc;  pin_d = req_pin;
        new_pin_d = req_new_pin;  amt_d = req_amount;
        if (req_op == OP_LOGIN) state_d = S_CHECK;
        else begin
          status_d = ST_ERR_BAD_OP;  bal_d = '0;  ret_d = S_IDLE;  state_d = S_RESP;
        end
      end
      S_CHECK: begin
        state_d = S_RESP;  ret_d = S_IDLE;  bal_d = '0;
        if ({1'b0, acc_q} >= (ACC_W+1)'(NUM_ACC)) status_d = ST_ERR_NO_ACC;
        else if (rd_lock) status_d = ST_ERR_LOCKED;
        else if (pin_q != rd_pin) begin
          wr_tries_en = 1'b1;  wr_tries = tries_inc;
          if (tries_inc >= TRY_W'(MAX_TRIES)) begin
            wr_lock_en = 1'b1;  wr_lock = 1'b1;  status_d = ST_ERR_LOCKED;
          end else status_d = ST_ERR_PIN;
        end else begin
          wr_tries_en = 1'b1;  wr_tries = '0;  wdr_d = '0;  cnt_d = '0;
          status_d = ST_OK;  bal_d = rd_bal;  ret_d = S_SESSION;
        end
      end
      S_SESSION: if (req_valid) begin
        op_d = req_op;  new_pin_d = req_new_pin;  amt_d = req_amount;
        cnt_d = '0;  state_d = S_EXEC;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_W'(TIMEOUT_CYC)) begin
          cnt_d = '0;  status_d = ST_ERR_TIMEOUT;  bal_d = '0;
          ret_d = S_IDLE;  state_d = S_RESP;
        end
      end
      S_EXEC: begin
        state_d = S_RESP;  ret_d = S_SESSION;  status_d = ST_OK;  bal_d = rd_bal;
        case (op_q)
          OP_BALANCE: ;
          OP_WITHDRAW:
            if (amt_q == '0 || amt_q > rd_bal) status_d = ST_ERR_FUNDS;
            else if (wd_sum > (BAL_W+1)'(SESSION_LIMIT)) status_d = ST_ERR_LIMIT;
            else begin
              wr_bal_en = 1'b1;  wr_bal = rd_bal - amt_q;
              bal_d = wr_bal;  wdr_d = wd_sum[BAL_W-1:0];
            end
          OP_DEPOSIT:
            if (dep_sum[BAL_W]) status_d = ST_ERR_OVERFLOW;
            else begin
              wr_bal_en = 1'b1;  wr_bal = dep_sum[BAL_W-1:0];  bal_d = wr_bal;
            end
          OP_CHANGE_PIN:
            if (new_pin_q == rd_pin) status_d = ST_ERR_SAME_PIN;
            else wr_pin_en = 1'b1;
          OP_LOGOUT: begin
            ret_d = S_IDLE;  bal_d = '0;  wdr_d = '0;
          end
          default: status_d = ST_ERR_BAD_OP;
        endcase
      end
      S_RESP: if (rsp_ready) begin
        state_d = ret_q;  cnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;  ret_q <= S_IDLE;  status_q <= ST_OK;
      op_q <= '0;  acc_q <= '0;  pin_q <= '0;  new_pin_q <= '0;
      amt_q <= '0;  bal_q <= '0;  wdr_q <= '0;  cnt_q <= '0;
    end else begin
      state_q <= state_d;  ret_q <= ret_d;  status_q <= status_d;
      op_q <= op_d;  acc_q <= acc_d;  pin_q <= pin_d;  new_pin_q <= new_pin_d;
      amt_q <= amt_d;  bal_q <= bal_d;  wdr_q <= wdr_d;  cnt_q <= cnt_d;
    end
  end

  assign rsp_status  = status_q;
  assign rsp_balance = bal_q;
  assign dbg_state_o = state_q;

endmodule
